// File: rtl/shot_responder_pkg.sv
// Shared game definitions for the battleship shot responder: board defaults,
// position field layout, response codes and the responder state type.
package shot_responder_pkg;

  localparam int GRID_N_DEFAULT     = 10;
  localparam int SHIP_CELLS_DEFAULT = 20;

  // Packed position byte: row in the high nibble, column in the low nibble.
  localparam int ROW_MSB = 7;
  localparam int ROW_LSB = 4;
  localparam int COL_MSB = 3;
  localparam int COL_LSB = 0;

  localparam logic [1:0] RESP_MISS    = 2'd0;
  localparam logic [1:0] RESP_HIT     = 2'd1;
  localparam logic [1:0] RESP_REPEAT  = 2'd2;
  localparam logic [1:0] RESP_INVALID = 2'd3;

  typedef enum logic [2:0] {
    SETUP,
    ARMED,
    LOOKUP,
    RESPOND,
    LOST
  } state_t;

endpackage

// File: rtl/shot_responder_cell_decode.sv
// Maps a packed row/column byte onto a linear board index plus an on-board flag.
module cell_decode
  import shot_responder_pkg::*;
#(
  parameter int GRID_N = GRID_N_DEFAULT
) (
  input  logic [7:0] pos,
  output logic       valid,
  output logic [6:0] idx
);

  localparam logic [3:0] SIDE  = 4'(GRID_N);
  localparam logic [6:0] SIDE7 = 7'(GRID_N);

  logic [3:0] row;
  logic [3:0] col;

  assign row   = pos[ROW_MSB:ROW_LSB];
  assign col   = pos[COL_MSB:COL_LSB];
  assign valid = (row < SIDE) && (col < SIDE);
  // Index is meaningless when valid is low; callers must gate on valid.
  assign idx   = 7'(row) * SIDE7 + 7'(col);

endmodule

// File: rtl/shot_responder.sv
// Own-board keeper: collects ship placements, then answers enemy shots
// one at a time with MISS/HIT/REPEAT/INVALID until every ship cell is hit.
module shot_responder
  import shot_responder_pkg::*;
#(
  parameter int GRID_N     = GRID_N_DEFAULT,
  parameter int SHIP_CELLS = SHIP_CELLS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       place_we,
  input  logic [7:0] place_pos,
  input  logic       arm,
  input  logic       shot_valid,
  input  logic [7:0] shot_pos,
  output logic       shot_ready,
  output logic       resp_valid,
  output logic [1:0] resp_code,
  output logic [7:0] resp_pos,
  input  logic       resp_ready,
  output logic [4:0] ship_count,
  output logic [4:0] hits_left,
  output logic       all_sunk,
  output logic [3:0] state_led
);

  localparam int         CELLS       = GRID_N * GRID_N;
  localparam logic [4:0] SHIP_TARGET = 5'(SHIP_CELLS);

  state_t           state;
  state_t           state_next;
  logic [CELLS-1:0] ship_map;
  logic [CELLS-1:0] shot_map;
  logic [7:0]       shot_pos_q;
  logic             place_ok;
  logic [6:0]       place_idx;
  logic             shot_ok;
  logic [6:0]       shot_idx;
  logic             fleet_full;
  logic             place_fire;

  cell_decode #(.GRID_N(GRID_N)) u_place_decode (
    .pos   (place_pos),
    .valid (place_ok),
    .idx   (place_idx)
  );

  cell_decode #(.GRID_N(GRID_N)) u_shot_decode (
    .pos   (shot_pos_q),
    .valid (shot_ok),
    .idx   (shot_idx)
  );

  assign fleet_full = (ship_count == SHIP_TARGET);
  assign place_fire = (state == SETUP) && place_we && place_ok &&
                      !ship_map[place_idx] && !fleet_full;

  always_ff @(posedge clk) begin
    if (rst) state <= SETUP;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    shot_ready = 1'b0;
    resp_valid = 1'b0;
    all_sunk   = 1'b0;
    state_led  = 4'b1000;
    unique case (state)
      SETUP: begin
        if (arm && fleet_full) state_next = ARMED;
      end
      ARMED: begin
        shot_ready = 1'b1;
        state_led  = 4'b0100;
        if (shot_valid) state_next = LOOKUP;
      end
      LOOKUP: begin
        state_led  = 4'b0010;
        state_next = RESPOND;
      end
      RESPOND: begin
        resp_valid = 1'b1;
        state_led  = 4'b0010;
        if (resp_ready) state_next = (hits_left == 5'd0) ? LOST : ARMED;
      end
      LOST: begin
        all_sunk  = 1'b1;
        state_led = 4'b0001;
      end
      default: state_next = SETUP;
    endcase
  end

  // Board, counters and the response registers; the response is resolved
  // in LOOKUP so it is already stable when RESPOND raises resp_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      ship_map   <= '0;
      shot_map   <= '0;
      ship_count <= '0;
      hits_left  <= '0;
      shot_pos_q <= '0;
      resp_code  <= RESP_MISS;
      resp_pos   <= '0;
    end else begin
      case (state)
        SETUP: begin
          if (place_fire) begin
            ship_map[place_idx] <= 1'b1;
            ship_count          <= ship_count + 5'd1;
          end
          if (arm && fleet_full) hits_left <= SHIP_TARGET;
        end
        ARMED: begin
          if (shot_valid) shot_pos_q <= shot_pos;
        end
        LOOKUP: begin
          resp_pos <= shot_pos_q;
          if (!shot_ok) begin
            resp_code <= RESP_INVALID;
          end else if (shot_map[shot_idx]) begin
            resp_code <= RESP_REPEAT;
          end else begin
            shot_map[shot_idx] <= 1'b1;
            if (ship_map[shot_idx]) begin
              resp_code <= RESP_HIT;
              if (hits_left != 5'd0) hits_left <= hits_left - 5'd1;
            end else begin
              resp_code <= RESP_MISS;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
